// File: rtl/cpu_trace_pkg.sv
// Shared types and width helpers for the CPU write-back trace buffer.
package cpu_trace_pkg;

  localparam int unsigned TR_DATA_W = 32;
  localparam int unsigned TR_ADDR_W = 32;
  localparam int unsigned TR_CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_HALTED,
    ST_TIMEOUT
  } state_e;

  // Trace record at the default widths; the top re-derives it at its own parameter widths.
  typedef struct packed {
    logic                 kind;
    logic [TR_CNT_W-1:0]  cycle;
    logic [TR_ADDR_W-1:0] addr;
    logic [TR_DATA_W-1:0] data;
  } trace_entry_t;

  function automatic int unsigned ptr_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned bits_for(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Circular trace buffer with overwrite/drop policy and a registered head entry on a valid/ready port.
module trace_fifo
  import cpu_trace_pkg::*;
#(
  parameter type         entry_t = trace_entry_t,
  parameter int unsigned DEPTH   = 16,
  parameter bit          WRAP    = 1'b1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  entry_t                       entry_i,
  input  logic                         drop_i,
  output logic                         valid_o,
  input  logic                         ready_i,
  output entry_t                       head_o,
  output logic [bits_for(DEPTH)-1:0]   count_o,
  output logic                         overflow_o
);

  localparam int unsigned PW = ptr_bits(DEPTH);
  localparam int unsigned CW = bits_for(DEPTH);

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  entry_t        head_q, head_d;
  logic          valid_q, valid_d;
  logic          ovf_q, ovf_d;
  logic          pop_c, full_c, wr_en_c;

  // Pointer/count update; a full buffer either advances the head (wrap) or rejects the push.
  always_comb begin
    pop_c    = valid_q & ready_i;
    full_c   = (count_q == CW'(DEPTH));
    wr_en_c  = push_i & (~full_c | pop_c | WRAP);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | drop_i;
    if (wr_en_c) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_c || (wr_en_c && full_c)) rd_ptr_d = rd_ptr_q + PW'(1);
    if (wr_en_c && !pop_c && !full_c) count_d = count_q + CW'(1);
    else if (pop_c && !wr_en_c) count_d = count_q - CW'(1);
    if (push_i && full_c && !pop_c) ovf_d = 1'b1;
    valid_d = (count_d != '0);
    head_d  = '0;
    // The new head may be the entry being written this very cycle.
    if (valid_d) head_d = (wr_en_c && (wr_ptr_q == rd_ptr_d)) ? entry_i : mem_q[rd_ptr_d];
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_c) mem_q[wr_ptr_q] <= entry_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
    end
  end

  assign valid_o    = valid_q;
  assign head_o     = head_q;
  assign count_o    = count_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/cpu_trace_buffer.sv
// Write-back trace capture with halt/timeout detection for the single-cycle CPU.
// Define CPU_TRACE_MEM_EN to also trace data-memory writes (kind=1).
module cpu_trace_buffer
  import cpu_trace_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned PC_W     = 32,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned HALT_CYC = 4,
  parameter int unsigned MAX_CYC  = 500,
  parameter bit          WRAP     = 1'b1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic [PC_W-1:0]            pc_i,
  input  logic                       rf_we_i,
  input  logic [REG_AW-1:0]          rf_addr_i,
  input  logic [DATA_W-1:0]          rf_data_i,
`ifdef CPU_TRACE_MEM_EN
  input  logic                       mem_we_i,
  input  logic [PC_W-1:0]            mem_addr_i,
  input  logic [DATA_W-1:0]          mem_data_i,
`endif
  output logic                       rd_valid_o,
  input  logic                       rd_ready_i,
  output logic [CNT_W-1:0]           rd_cycle_o,
  output logic                       rd_kind_o,
  output logic [PC_W-1:0]            rd_addr_o,
  output logic [DATA_W-1:0]          rd_data_o,
  output logic [CNT_W-1:0]           cycle_o,
  output logic [bits_for(DEPTH)-1:0] count_o,
  output logic                       overflow_o,
  output logic                       done_o,
  output logic                       timeout_o
);

  localparam int unsigned SW = bits_for(HALT_CYC);

  typedef struct packed {
    logic              kind;
    logic [CNT_W-1:0]  cycle;
    logic [PC_W-1:0]   addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [SW-1:0]   stab_q, stab_d;
  logic [SW-1:0]   run_len_c;
  logic [PC_W-1:0] pc_prev_q;
  logic            pc_same_c;
  logic            done_q, done_d;
  logic            timeout_q, timeout_d;
  logic            reg_push_c, push_c, drop_c;
  entry_t          entry_c, head;
`ifdef CPU_TRACE_MEM_EN
  logic            mem_push_c;
`endif

  // Run-length of the current PC value counts the present cycle; halt wins over timeout.
  always_comb begin
    state_d   = state_q;
    cycle_d   = cycle_q;
    stab_d    = '0;
    pc_same_c = (pc_i == pc_prev_q);
    run_len_c = pc_same_c ? stab_q + SW'(1) : SW'(1);
    unique case (state_q)
      ST_IDLE: if (start_i) state_d = ST_RUN;
      ST_RUN: begin
        cycle_d = (&cycle_q) ? cycle_q : cycle_q + CNT_W'(1);
        stab_d  = run_len_c;
        if (run_len_c == SW'(HALT_CYC)) state_d = ST_HALTED;
        else if (cycle_q == CNT_W'(MAX_CYC - 1)) state_d = ST_TIMEOUT;
      end
      default: ;
    endcase
    done_d    = (state_d == ST_HALTED) || (state_d == ST_TIMEOUT);
    timeout_d = (state_d == ST_TIMEOUT);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      cycle_q   <= '0;
      stab_q    <= '0;
      pc_prev_q <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cycle_q   <= cycle_d;
      stab_q    <= stab_d;
      pc_prev_q <= pc_i;
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end

  // Capture filter: RUN only, r0 ignored; a colliding memory write loses to the register write.
  always_comb begin
    reg_push_c    = (state_q == ST_RUN) && rf_we_i && (rf_addr_i != '0);
    entry_c       = '0;
    entry_c.cycle = cycle_q;
    entry_c.addr  = PC_W'(rf_addr_i);
    entry_c.data  = rf_data_i;
`ifdef CPU_TRACE_MEM_EN
    mem_push_c = (state_q == ST_RUN) && mem_we_i;
    push_c     = reg_push_c || mem_push_c;
    drop_c     = reg_push_c && mem_push_c;
    if (!reg_push_c && mem_push_c) begin
      entry_c.kind = 1'b1;
      entry_c.addr = mem_addr_i;
      entry_c.data = mem_data_i;
    end
`else
    push_c = reg_push_c;
    drop_c = 1'b0;
`endif
  end

  trace_fifo #(
    .entry_t (entry_t),
    .DEPTH   (DEPTH),
    .WRAP    (WRAP)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (push_c),
    .entry_i    (entry_c),
    .drop_i     (drop_c),
    .valid_o    (rd_valid_o),
    .ready_i    (rd_ready_i),
    .head_o     (head),
    .count_o    (count_o),
    .overflow_o (overflow_o)
  );

  assign rd_cycle_o = head.cycle;
  assign rd_kind_o  = head.kind;
  assign rd_addr_o  = head.addr;
  assign rd_data_o  = head.data;
  assign cycle_o    = cycle_q;
  assign done_o     = done_q;
  assign timeout_o  = timeout_q;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Directed bench: a wrapping DEPTH=4/MAX_CYC=20 instance and a dropping DEPTH=4 instance share stimulus.
module tb_cpu_trace_buffer;

  logic        clk_i = 1'b0;
  logic        rst_i, start_i, rf_we_i, rd_ready_i;
  logic [31:0] pc_i, rf_data_i;
  logic [4:0]  rf_addr_i;
  logic        pc_run;

  logic        a_valid, a_kind, a_ovf, a_done, a_timeout;
  logic [15:0] a_rcyc, a_cycle;
  logic [31:0] a_addr, a_data;
  logic [2:0]  a_count;
  logic        b_valid, b_kind, b_ovf, b_done, b_timeout;
  logic [15:0] b_rcyc, b_cycle;
  logic [31:0] b_addr, b_data;
  logic [2:0]  b_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  cpu_trace_buffer #(.DEPTH(4), .MAX_CYC(20), .WRAP(1'b1)) u_dut_a (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .pc_i(pc_i),
    .rf_we_i(rf_we_i), .rf_addr_i(rf_addr_i), .rf_data_i(rf_data_i),
`ifdef CPU_TRACE_MEM_EN
    .mem_we_i(1'b0), .mem_addr_i(32'd0), .mem_data_i(32'd0),
`endif
    .rd_valid_o(a_valid), .rd_ready_i(rd_ready_i), .rd_cycle_o(a_rcyc),
    .rd_kind_o(a_kind), .rd_addr_o(a_addr), .rd_data_o(a_data),
    .cycle_o(a_cycle), .count_o(a_count), .overflow_o(a_ovf),
    .done_o(a_done), .timeout_o(a_timeout)
  );

  cpu_trace_buffer #(.DEPTH(4), .WRAP(1'b0)) u_dut_b (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .pc_i(pc_i),
    .rf_we_i(rf_we_i), .rf_addr_i(rf_addr_i), .rf_data_i(rf_data_i),
`ifdef CPU_TRACE_MEM_EN
    .mem_we_i(1'b0), .mem_addr_i(32'd0), .mem_data_i(32'd0),
`endif
    .rd_valid_o(b_valid), .rd_ready_i(rd_ready_i), .rd_cycle_o(b_rcyc),
    .rd_kind_o(b_kind), .rd_addr_o(b_addr), .rd_data_o(b_data),
    .cycle_o(b_cycle), .count_o(b_count), .overflow_o(b_ovf),
    .done_o(b_done), .timeout_o(b_timeout)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Outputs are registered, so inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
    if (pc_run) pc_i = pc_i + 32'd4;
  endtask

  task automatic do_reset();
    rst_i = 1'b1; start_i = 1'b0; rf_we_i = 1'b0; rd_ready_i = 1'b0;
    rf_addr_i = '0; rf_data_i = '0;
    tick(); tick();
    rst_i = 1'b0;
  endtask

  task automatic rf_write(input logic [4:0] a, input logic [31:0] d);
    rf_we_i = 1'b1; rf_addr_i = a; rf_data_i = d;
  endtask

  initial begin
    pc_i = 32'h100; pc_run = 1'b1;
    do_reset();
    check("rst_valid", a_valid, 0);
    check("rst_count", a_count, 0);
    check("rst_cycle", a_cycle, 0);
    check("rst_done", a_done, 0);
    check("rst_timeout", a_timeout, 0);
    check("rst_ovf", a_ovf, 0);
    check("rst_data", a_data, 0);

    // Basic capture r1=5 @3, r2=7 @4, consumer always ready.
    start_i = 1'b1; tick();
    check("run_cycle0", a_cycle, 0);
    tick(); tick(); tick();
    check("run_cycle3", a_cycle, 3);
    rf_write(5'd1, 32'd5); rd_ready_i = 1'b1; tick();
    check("e1_valid", a_valid, 1);
    check("e1_cycle", a_rcyc, 3);
    check("e1_kind", a_kind, 0);
    check("e1_addr", a_addr, 1);
    check("e1_data", a_data, 5);
    rf_write(5'd2, 32'd7); tick();
    rf_we_i = 1'b0;
    check("e2_valid", a_valid, 1);
    check("e2_cycle", a_rcyc, 4);
    check("e2_addr", a_addr, 2);
    check("e2_data", a_data, 7);
    tick();
    check("drain_count", a_count, 0);
    check("drain_valid", a_valid, 0);

    // Writes to r0 are ignored.
    rf_write(5'd0, 32'd9); tick();
    rf_we_i = 1'b0; tick();
    check("r0_count", a_count, 0);
    check("r0_valid", a_valid, 0);

    // Six writes into DEPTH=4 with no reader: wrap keeps 3..6, drop keeps 1..4.
    do_reset();
    start_i = 1'b1; tick();
    for (int i = 1; i <= 6; i++) begin
      rf_write(5'(i), 32'(i)); tick();
      if (i == 4) begin
        check("full_ovf_a", a_ovf, 0);
        check("full_ovf_b", b_ovf, 0);
        check("full_count", a_count, 4);
      end
    end
    rf_we_i = 1'b0;
    check("wrap_count", a_count, 4);
    check("wrap_ovf", a_ovf, 1);
    check("drop_count", b_count, 4);
    check("drop_ovf", b_ovf, 1);
    rd_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("wrap_data%0d", k), a_data, 64'(3 + k));
      check($sformatf("wrap_cyc%0d", k), a_rcyc, 64'(2 + k));
      check($sformatf("drop_data%0d", k), b_data, 64'(1 + k));
      check($sformatf("drop_addr%0d", k), b_addr, 64'(1 + k));
      check($sformatf("drop_cyc%0d", k), b_rcyc, 64'(k));
      check($sformatf("drop_valid%0d", k), b_valid, 1);
      tick();
    end
    check("wrap_empty", a_valid, 0);
    check("drop_empty", b_count, 0);
    check("ovf_sticky", a_ovf, 1);
    check("drop_kind", b_kind, 0);

    // Full buffer with simultaneous push and pop.
    do_reset();
    start_i = 1'b1; tick();
    for (int i = 0; i < 4; i++) begin
      rf_write(5'(i + 1), 32'h11 + 32'(i)); tick();
    end
    rf_write(5'd5, 32'h15); rd_ready_i = 1'b1;
    check("pp_head0", a_data, 32'h11);
    tick();
    rf_we_i = 1'b0;
    check("pp_count_a", a_count, 4);
    check("pp_ovf_a", a_ovf, 0);
    check("pp_count_b", b_count, 4);
    check("pp_ovf_b", b_ovf, 0);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("pp_data%0d", k), a_data, 64'(32'h12 + k));
      tick();
    end
    check("pp_empty", a_count, 0);

    // PC held at 0x40: halt after four RUN cycles; later writes not captured.
    do_reset();
    pc_run = 1'b0; pc_i = 32'h40;
    start_i = 1'b1;
    tick(); tick(); tick(); tick();
    check("halt_early", a_done, 0);
    tick();
    check("halt_done", a_done, 1);
    check("halt_tmo", a_timeout, 0);
    check("halt_cycle", a_cycle, 4);
    rf_write(5'd3, 32'd1); tick();
    rf_we_i = 1'b0; tick();
    check("halt_nocap", a_count, 0);
    check("halt_frozen", a_cycle, 4);

    // PC toggling: timeout once cycle_o has reached MAX_CYC-1.
    do_reset();
    pc_run = 1'b1; start_i = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    check("tmo_cycle19", a_cycle, 19);
    check("tmo_early", a_timeout, 0);
    tick();
    check("tmo_set", a_timeout, 1);
    check("tmo_done", a_done, 1);
    check("tmo_b_none", b_timeout, 0);
    check("tmo_b_done", b_done, 0);
    tick();
    check("tmo_frozen", a_cycle, 20);
    check("tmo_b_cycle", b_cycle, 21);

    // Reset mid-run with three entries pending.
    do_reset();
    start_i = 1'b1; tick();
    for (int i = 0; i < 3; i++) begin
      rf_write(5'(i + 1), 32'(i)); tick();
    end
    rf_we_i = 1'b0;
    check("pend_count", a_count, 3);
    check("pend_valid", a_valid, 1);
    rst_i = 1'b1; tick();
    check("mrst_valid", a_valid, 0);
    check("mrst_count", a_count, 0);
    check("mrst_cycle", a_cycle, 0);
    rst_i = 1'b0; start_i = 1'b0;
    tick(); tick();
    check("mrst_idle", a_cycle, 0);
    check("mrst_done", a_done, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
